// File: rtl/ram_scan_viewer_if.sv
// Board-side bundle for the RAM scan viewer: write port, scan controls and display outputs.
interface ram_scan_viewer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] DATA;
    logic [ADDR_W-1:0] ADDRESS;
    logic              WE;
    logic [1:0]        MODE;
    logic              STEP;
    logic [ADDR_W-1:0] RADDRESS;
    logic [DATA_W-1:0] QD;
    logic              QD_VALID;
    logic              TICK;
    logic              WRAP;

    modport master (
        output DATA, ADDRESS, WE, MODE, STEP,
        input  RADDRESS, QD, QD_VALID, TICK, WRAP
    );

    modport slave (
        input  DATA, ADDRESS, WE, MODE, STEP,
        output RADDRESS, QD, QD_VALID, TICK, WRAP
    );
endinterface

// File: rtl/ram_scan_viewer.sv
// RAM scan viewer: board-written simple-dual-port RAM with a scanning read pointer
// (auto-up, auto-down, manual step, hold) and a registered, write-first read port.
module ram_scan_viewer #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int TICK_DIV = 50000000
) (
    input logic             CLK,
    input logic             RESET,
    ram_scan_viewer_if.slave bus
);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [1:0]      M_DOWN   = 2'b01;
    localparam logic [1:0]      M_STEP   = 2'b10;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_eff;
    logic [1:0]        mode_q;
    logic              tick_q;
    logic              step_q;
    logic [ADDR_W-1:0] raddr;
    logic              wrap_q;
    logic [DATA_W-1:0] qd_q;
    logic              qd_valid_q;

    logic              auto_mode;
    logic              adv;
    logic              move_up;
    logic              at_wrap;

    // Advance decode; a mode change is treated as count 0 in the very cycle it happens,
    // so the first tick in the new mode lands exactly TICK_DIV cycles later.
    always_comb begin
        auto_mode = ~bus.MODE[1];
        cnt_eff   = (bus.MODE != mode_q) ? '0 : cnt;
        adv       = (auto_mode && tick_q) ||
                    ((bus.MODE == M_STEP) && bus.STEP && !step_q);
        move_up   = (bus.MODE != M_DOWN);
        at_wrap   = move_up ? (raddr == '1) : (raddr == '0);
    end

    // Scan-rate divider: free-running in auto modes, parked at 0 otherwise.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt    <= '0;
            tick_q <= 1'b0;
            mode_q <= bus.MODE;
        end else begin
            mode_q <= bus.MODE;
            if (!auto_mode) begin
                cnt    <= '0;
                tick_q <= 1'b0;
            end else if (cnt_eff == CNT_LAST) begin
                cnt    <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt    <= cnt_eff + 1'b1;
                tick_q <= 1'b0;
            end
        end
    end

    // Read pointer, wrap flag and STEP history; history resets high so a held STEP is ignored.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            raddr  <= '0;
            wrap_q <= 1'b0;
            step_q <= 1'b1;
        end else begin
            step_q <= bus.STEP;
            wrap_q <= adv && at_wrap;
            if (adv) begin
                raddr <= move_up ? raddr + 1'b1 : raddr - 1'b1;
            end
        end
    end

    // Registered read with write-first bypass when the write hits the scanned word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            qd_q       <= '0;
            qd_valid_q <= 1'b0;
        end else begin
            qd_valid_q <= !adv;
            if (bus.WE && (bus.ADDRESS == raddr)) begin
                qd_q <= bus.DATA;
            end else begin
                qd_q <= mem[raddr];
            end
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (bus.WE) begin
            mem[bus.ADDRESS] <= bus.DATA;
        end
    end

    assign bus.RADDRESS = raddr;
    assign bus.QD       = qd_q;
    assign bus.QD_VALID = qd_valid_q;
    assign bus.TICK     = tick_q && auto_mode;
    assign bus.WRAP     = wrap_q;
endmodule

// File: tb/tb_ram_scan_viewer.sv
// Self-checking bench for ram_scan_viewer (DATA_W=8, ADDR_W=3, TICK_DIV=4).
module tb_ram_scan_viewer;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int TICK_DIV = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wrap;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    ram_scan_viewer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_scan_viewer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.MODE = 2'b10; bus.STEP = 1'b1;
        bus.WE = 1'b0; bus.DATA = '0; bus.ADDRESS = '0;
        repeat (3) cyc();
        checks++; if (bus.RADDRESS !== 3'd0) begin errors++; $display("FAIL reset_raddr got %0h want 0", bus.RADDRESS); end
        checks++; if (bus.QD !== 8'h00) begin errors++; $display("FAIL reset_qd got %0h want 0", bus.QD); end
        checks++; if (bus.QD_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.QD_VALID); end
        checks++; if (bus.TICK !== 1'b0) begin errors++; $display("FAIL reset_tick got %0b want 0", bus.TICK); end
        checks++; if (bus.WRAP !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0b want 0", bus.WRAP); end
        RESET = 1'b0;
        repeat (4) cyc();
        checks++; if (bus.RADDRESS !== 3'd0) begin errors++; $display("FAIL step_through_reset got %0h want 0", bus.RADDRESS); end
        checks++; if (bus.QD_VALID !== 1'b1) begin errors++; $display("FAIL valid_after_release got %0b want 1", bus.QD_VALID); end
        bus.STEP = 1'b0;
        bus.MODE = 2'b11;
    endtask

    task automatic test_fill_hold();
        for (int i = 0; i < 8; i++) begin
            bus.WE = 1'b1; bus.ADDRESS = 3'(i); bus.DATA = 8'hA0 + 8'(i);
            cyc();
        end
        bus.WE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (bus.RADDRESS !== 3'd0 || bus.TICK !== 1'b0 || bus.QD !== 8'hA0 || bus.QD_VALID !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d got addr=%0h tick=%0b qd=%0h v=%0b want addr=0 tick=0 qd=a0 v=1",
                         i, bus.RADDRESS, bus.TICK, bus.QD, bus.QD_VALID);
            end
        end
    endtask

    task automatic test_auto_up();
        int n = 0; int last_tick = -1; int wraps = 0;
        logic [ADDR_W-1:0] prev;
        logic pending = 1'b0;
        logic [DATA_W-1:0] pend_data = '0;
        exp_t e;
        exp_q.delete();
        for (int i = 1; i <= 8; i++)
            exp_q.push_back('{addr: 3'(i % 8), data: 8'hA0 + 8'(i % 8), wrap: (i == 8)});
        prev = bus.RADDRESS;
        bus.MODE = 2'b00;
        while ((exp_q.size() > 0 || pending) && n < 100) begin
            cyc(); n++;
            if (bus.TICK === 1'b1) begin
                checks++;
                if (last_tick < 0 && n != TICK_DIV) begin errors++; $display("FAIL up_first_tick got %0d want %0d", n, TICK_DIV); end
                if (last_tick >= 0 && n - last_tick != TICK_DIV) begin errors++; $display("FAIL up_tick_gap got %0d want %0d", n - last_tick, TICK_DIV); end
                last_tick = n;
            end
            if (bus.WRAP === 1'b1) wraps++;
            if (bus.RADDRESS !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL up_extra_step got %0h want none", bus.RADDRESS);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.RADDRESS !== e.addr || bus.WRAP !== e.wrap || bus.QD_VALID !== 1'b0) begin
                        errors++;
                        $display("FAIL up_step got addr=%0h wrap=%0b v=%0b want addr=%0h wrap=%0b v=0",
                                 bus.RADDRESS, bus.WRAP, bus.QD_VALID, e.addr, e.wrap);
                    end
                    pending = 1'b1; pend_data = e.data;
                end
                prev = bus.RADDRESS;
            end else if (pending) begin
                checks++;
                if (bus.QD !== pend_data || bus.QD_VALID !== 1'b1) begin
                    errors++; $display("FAIL up_qd got %0h v=%0b want %0h v=1", bus.QD, bus.QD_VALID, pend_data);
                end
                pending = 1'b0;
            end
        end
        checks++; if (n >= 100) begin errors++; $display("FAIL up_timeout got %0d left want 0", exp_q.size()); end
        checks++; if (wraps != 1) begin errors++; $display("FAIL up_wrap_count got %0d want 1", wraps); end
        bus.MODE = 2'b11;
        cyc();
    endtask

    task automatic test_auto_down();
        int n = 0; int wraps = 0;
        logic [ADDR_W-1:0] prev;
        logic pending = 1'b0;
        logic [DATA_W-1:0] pend_data = '0;
        exp_t e;
        bus.MODE = 2'b10;
        bus.STEP = 1'b1; cyc();
        bus.STEP = 1'b0; cyc();
        checks++; if (bus.RADDRESS !== 3'd1) begin errors++; $display("FAIL down_start got %0h want 1", bus.RADDRESS); end
        exp_q.delete();
        exp_q.push_back('{addr: 3'd0, data: 8'hA0, wrap: 1'b0});
        exp_q.push_back('{addr: 3'd7, data: 8'hA7, wrap: 1'b1});
        exp_q.push_back('{addr: 3'd6, data: 8'hA6, wrap: 1'b0});
        prev = bus.RADDRESS;
        bus.MODE = 2'b01;
        while ((exp_q.size() > 0 || pending) && n < 60) begin
            cyc(); n++;
            if (bus.WRAP === 1'b1) wraps++;
            if (bus.RADDRESS !== prev) begin
                checks++;
                e = exp_q.pop_front();
                if (bus.RADDRESS !== e.addr || bus.WRAP !== e.wrap || bus.QD_VALID !== 1'b0) begin
                    errors++;
                    $display("FAIL down_step got addr=%0h wrap=%0b v=%0b want addr=%0h wrap=%0b v=0",
                             bus.RADDRESS, bus.WRAP, bus.QD_VALID, e.addr, e.wrap);
                end
                pending = 1'b1; pend_data = e.data;
                prev = bus.RADDRESS;
            end else if (pending) begin
                checks++;
                if (bus.QD !== pend_data || bus.QD_VALID !== 1'b1) begin
                    errors++; $display("FAIL down_qd got %0h v=%0b want %0h v=1", bus.QD, bus.QD_VALID, pend_data);
                end
                pending = 1'b0;
            end
            if (exp_q.size() == 0 && !pending) bus.MODE = 2'b11;
        end
        bus.MODE = 2'b11;
        checks++; if (n >= 60) begin errors++; $display("FAIL down_timeout got %0d left want 0", exp_q.size()); end
        checks++; if (wraps != 1) begin errors++; $display("FAIL down_wrap_count got %0d want 1", wraps); end
        cyc();
    endtask

    task automatic test_manual_step();
        int changes = 0; int ticks = 0; int wraps = 0;
        logic [ADDR_W-1:0] prev;
        logic [ADDR_W-1:0] want;
        exp_t e;
        bus.MODE = 2'b10;
        prev = bus.RADDRESS;
        want = prev + 3'd1;
        for (int i = 0; i < 13; i++) begin
            bus.STEP = (i < 10);
            cyc();
            if (bus.TICK === 1'b1) ticks++;
            if (bus.WRAP === 1'b1) wraps++;
            if (bus.RADDRESS !== prev) begin changes++; prev = bus.RADDRESS; end
        end
        checks++; if (changes != 1) begin errors++; $display("FAIL step_held got %0d advances want 1", changes); end
        checks++; if (bus.RADDRESS !== want) begin errors++; $display("FAIL step_held_addr got %0h want %0h", bus.RADDRESS, want); end
        exp_q.delete();
        for (int p = 0; p < 3; p++) begin
            exp_q.push_back('{addr: want + 3'(p + 1), data: '0, wrap: 1'b0});
            for (int k = 0; k < 3; k++) begin
                bus.STEP = (k == 0);
                cyc();
                if (bus.TICK === 1'b1) ticks++;
                if (bus.WRAP === 1'b1) wraps++;
                if (bus.RADDRESS !== prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL step_extra got %0h want none", bus.RADDRESS);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.RADDRESS !== e.addr) begin errors++; $display("FAIL step_pulse got %0h want %0h", bus.RADDRESS, e.addr); end
                    end
                    prev = bus.RADDRESS;
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL step_missing got %0d pending want 0", exp_q.size()); end
        checks++; if (ticks != 0) begin errors++; $display("FAIL step_ticks got %0d want 0", ticks); end
        checks++; if (wraps != 1) begin errors++; $display("FAIL step_wraps got %0d want 1", wraps); end
        bus.MODE = 2'b11;
        cyc(); cyc();
        checks++; if (bus.RADDRESS !== 3'd2 || bus.QD !== 8'hA2) begin errors++; $display("FAIL step_final got %0h/%0h want 2/a2", bus.RADDRESS, bus.QD); end
    endtask

    task automatic test_collision();
        bus.WE = 1'b1; bus.ADDRESS = 3'd3; bus.DATA = 8'h77;
        cyc();
        checks++; if (bus.QD !== 8'hA2) begin errors++; $display("FAIL no_collision got %0h want a2", bus.QD); end
        bus.ADDRESS = 3'd2; bus.DATA = 8'h5C;
        cyc();
        checks++; if (bus.QD !== 8'h5C || bus.QD_VALID !== 1'b1) begin errors++; $display("FAIL collision got %0h v=%0b want 5c v=1", bus.QD, bus.QD_VALID); end
        bus.WE = 1'b0;
        cyc();
        checks++; if (bus.QD !== 8'h5C) begin errors++; $display("FAIL collision_stored got %0h want 5c", bus.QD); end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        bus.MODE = 2'b00;
        while (bus.RADDRESS !== 3'd5 && n < 60) begin cyc(); n++; end
        checks++; if (n >= 60) begin errors++; $display("FAIL mid_reset_reach got %0h want 5", bus.RADDRESS); end
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        checks++; if (bus.RADDRESS !== 3'd0 || bus.QD_VALID !== 1'b0) begin errors++; $display("FAIL mid_reset got addr=%0h v=%0b want 0/0", bus.RADDRESS, bus.QD_VALID); end
        cyc();
        checks++; if (bus.QD !== 8'hA0 || bus.QD_VALID !== 1'b1) begin errors++; $display("FAIL ram_kept got %0h v=%0b want a0 v=1", bus.QD, bus.QD_VALID); end
        checks++; if (bus.TICK !== 1'b0 || bus.RADDRESS !== 3'd0) begin errors++; $display("FAIL divider_restart got tick=%0b addr=%0h want 0/0", bus.TICK, bus.RADDRESS); end
        bus.MODE = 2'b11;
    endtask

    initial begin
        test_reset();
        test_fill_hold();
        test_auto_up();
        test_auto_down();
        test_manual_step();
        test_collision();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
